code_expander: RTL and testbench

- Sequential decoder that is the receiving end of the priority-encoder path.
- Accepts a stream of WIDTH_IN-bit codes over a valid/ready handshake and buffers them in a small FIFO.
- Emits each code as a 2^WIDTH_IN-bit vector, either one-hot or thermometer ("ladder"), over a second valid/ready handshake.
- Keeps a sticky OR-accumulation of all emitted vectors and a count of emitted vectors, so encoder/decoder loopback can be checked in-system.

---
 rtl/code_expander_if.sv | 39 +++
 rtl/code_expander.sv | 96 +++++++++
 tb/tb_code_expander.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/code_expander_if.sv
// code_expander_if
//   Handshake bundle between a code source, the code_expander and the
//   downstream vector consumer.
//   Signals:
//     in_valid / in_ready   : code offer / FIFO can accept
//     in_code, in_mode      : code to decode, 0 = one-hot, 1 = thermometer
//     out_valid / out_ready : decoded vector available / consumer takes it
//     out_vector            : decoded vector of the FIFO head entry
//     acc_clear             : synchronous clear of acc_vector
//     acc_vector            : OR of all emitted vectors since reset/clear
//     out_count             : emitted-vector count, modulo 2^CNT_W
//   Modports: master = source/consumer side, slave = code_expander side.
interface code_expander_if #(
   parameter int WIDTH_IN = 3,
   parameter int CNT_W    = 4
);
   localparam int OUT_W = 1 << WIDTH_IN;

   logic                in_valid;
   logic                in_ready;
   logic [WIDTH_IN-1:0] in_code;
   logic                in_mode;
   logic                out_valid;
   logic                out_ready;
   logic [OUT_W-1:0]    out_vector;
   logic                acc_clear;
   logic [OUT_W-1:0]    acc_vector;
   logic [CNT_W-1:0]    out_count;

   modport master (
      output in_valid, in_code, in_mode, out_ready, acc_clear,
      input  in_ready, out_valid, out_vector, acc_vector, out_count
   );

   modport slave (
      input  in_valid, in_code, in_mode, out_ready, acc_clear,
      output in_ready, out_valid, out_vector, acc_vector, out_count
   );
endinterface

// File: rtl/code_expander.sv
// code_expander
//   Receiving end of the priority-encoder path. Buffers {mode, code}
//   entries in a DEPTH-entry FIFO and emits each as a 2^WIDTH_IN-bit
//   one-hot or thermometer vector. Keeps a sticky OR of emitted vectors
//   and a wrapping count of them for loopback checking.
//   Ports:
//     clk   : rising-edge clock
//     reset : synchronous, active-high reset
//     bus   : code_expander_if slave modport (both handshakes, accumulator,
//             counter)
module code_expander #(
   parameter int WIDTH_IN = 3,
   parameter int DEPTH    = 4,
   parameter int CNT_W    = 4
) (
   input  logic            clk,
   input  logic            reset,
   code_expander_if.slave  bus
);
   localparam int OUT_W = 1 << WIDTH_IN;
   localparam int AW    = $clog2(DEPTH);

   typedef logic [WIDTH_IN:0] entry_t;   // {mode, code}

   entry_t           r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             r_full;
   logic [OUT_W-1:0] r_acc;
   logic [CNT_W-1:0] r_out_count;

   logic             w_push;
   logic             w_pop;
   logic             w_empty;
   logic [AW:0]      w_count_nxt;
   entry_t           w_head;
   logic [OUT_W-1:0] w_vec;

   assign w_empty = (r_count == '0);
   assign w_head  = r_mem[r_rd_ptr];

   // in_ready comes from registered full only, so out_ready never reaches it
   assign w_push  = bus.in_valid && !r_full;
   assign w_pop   = !w_empty && bus.out_ready;

   assign w_count_nxt = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

   always_comb begin
      w_vec = '0;
      if (!w_empty) begin
         for (int unsigned i = 0; i < OUT_W; i++) begin
            if (w_head[WIDTH_IN])
               w_vec[i] = (i <= 32'(w_head[WIDTH_IN-1:0]));
            else
               w_vec[i] = (i == 32'(w_head[WIDTH_IN-1:0]));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push && !reset)
         r_mem[r_wr_ptr] <= {bus.in_mode, bus.in_code};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_full      <= 1'b0;
         r_acc       <= '0;
         r_out_count <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop) begin
            r_rd_ptr    <= r_rd_ptr + AW'(1);
            r_out_count <= r_out_count + CNT_W'(1);
         end
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == (AW+1)'(DEPTH));
         // clear takes effect before the OR of a same-cycle transfer
         if (bus.acc_clear)
            r_acc <= w_pop ? w_vec : '0;
         else if (w_pop)
            r_acc <= r_acc | w_vec;
      end
   end

   assign bus.in_ready   = !r_full;
   assign bus.out_valid  = !w_empty;
   assign bus.out_vector = w_vec;
   assign bus.acc_vector = r_acc;
   assign bus.out_count  = r_out_count;
endmodule

// File: tb/tb_code_expander.sv
// tb_code_expander
//   Directed scenarios with literal expectations, then randomized traffic,
//   all checked every cycle against a queue-based model of the expander.
module tb_code_expander;
   localparam int WIDTH_IN = 3;
   localparam int DEPTH    = 4;
   localparam int CNT_W    = 4;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   code_expander_if #(.WIDTH_IN(WIDTH_IN), .CNT_W(CNT_W)) bus ();

   code_expander #(.WIDTH_IN(WIDTH_IN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int vectors     = 0;
   int miscompares = 0;
   bit started     = 1'b0;

   // model state
   logic [3:0] mq[$];
   logic [7:0] m_acc = 8'h00;
   int         m_cnt = 0;
   bit         m_last_accept = 1'b0;

   function automatic logic [7:0] model_vec(input logic [3:0] e);
      int k;
      k = int'(e[2:0]);
      if (e[3]) return 8'((1 << (k + 1)) - 1);
      else      return 8'(1 << k);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   always @(posedge clk) begin : model
      bit pop;
      bit acc_ok;
      if (reset) begin
         mq.delete();
         m_acc = 8'h00;
         m_cnt = 0;
         m_last_accept = 1'b0;
      end else begin
         pop    = (mq.size() > 0) && bus.out_ready;
         acc_ok = bus.in_valid && (mq.size() < DEPTH);
         if (bus.acc_clear)
            m_acc = pop ? model_vec(mq[0]) : 8'h00;
         else if (pop)
            m_acc = m_acc | model_vec(mq[0]);
         if (pop) begin
            void'(mq.pop_front());
            m_cnt++;
         end
         if (acc_ok) mq.push_back({bus.in_mode, bus.in_code});
         m_last_accept = acc_ok;
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("in_ready",   32'(bus.in_ready),   32'(mq.size() < DEPTH));
         chk("out_valid",  32'(bus.out_valid),  32'(mq.size() > 0));
         chk("out_vector", 32'(bus.out_vector), 32'((mq.size() > 0) ? model_vec(mq[0]) : 8'h00));
         chk("acc_vector", 32'(bus.acc_vector), 32'(m_acc));
         chk("out_count",  32'(bus.out_count),  32'(m_cnt % 16));
      end
   end

   task automatic drive(input bit v, input logic [2:0] c, input bit m, input bit ordy, input bit clr);
      bus.in_valid  = v;
      bus.in_code   = c;
      bus.in_mode   = m;
      bus.out_ready = ordy;
      bus.acc_clear = clr;
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   logic [7:0] lad [8] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
   logic [2:0] bp  [5] = '{3'd2, 3'd4, 3'd6, 3'd1, 3'd7};

   initial begin
      bit v, m, o, c;
      logic [2:0] code;
      drive(0, 3'd0, 0, 0, 0);
      reset = 1'b1;
      cyc();
      started = 1'b1;
      cyc();
      reset = 1'b0;

      // reset state
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
      chk("rst_vector",    32'(bus.out_vector), 32'h00);
      chk("rst_acc",       32'(bus.acc_vector), 32'h00);
      chk("rst_count",     32'(bus.out_count),  32'd0);

      // thermometer ladder with free-running consumer
      for (int k = 0; k < 8; k++) begin
         drive(1, 3'(k), 1, 1, 0);
         cyc();
         chk("ladder_valid", 32'(bus.out_valid), 32'd1);
         chk("ladder_vec",   32'(bus.out_vector), 32'(lad[k]));
      end
      drive(0, 3'd0, 0, 1, 0);
      cyc();
      chk("ladder_count", 32'(bus.out_count),  32'd8);
      chk("ladder_acc",   32'(bus.acc_vector), 32'hFF);

      // backpressure: fill, hold code 7, then drain
      for (int i = 0; i < 4; i++) begin
         drive(1, bp[i], 0, 0, 0);
         cyc();
      end
      chk("bp_full", 32'(bus.in_ready), 32'd0);
      drive(1, bp[4], 0, 0, 0);
      cyc();
      chk("bp_still_full", 32'(bus.in_ready), 32'd0);
      chk("bp_head",       32'(bus.out_vector), 32'h04);
      drive(1, bp[4], 0, 1, 0);
      cyc();
      chk("bp_ready_back", 32'(bus.in_ready), 32'd1);
      chk("bp_vec1",       32'(bus.out_vector), 32'h10);
      drive(1, bp[4], 0, 1, 0);
      cyc();
      chk("bp_vec2", 32'(bus.out_vector), 32'h40);
      drive(0, 3'd0, 0, 1, 0);
      cyc();
      chk("bp_vec3", 32'(bus.out_vector), 32'h02);
      cyc();
      chk("bp_vec4", 32'(bus.out_vector), 32'h80);
      cyc();
      chk("bp_empty", 32'(bus.out_valid), 32'd0);
      chk("bp_count", 32'(bus.out_count), 32'd13);

      // simultaneous push/pop at occupancy 2
      drive(1, 3'd0, 0, 0, 0);
      cyc();
      drive(1, 3'd1, 0, 0, 0);
      cyc();
      for (int j = 2; j < 8; j++) begin
         drive(1, 3'(j), 0, 1, 0);
         cyc();
         chk("pp_vec",   32'(bus.out_vector), 32'(1 << (j - 1)));
         chk("pp_ready", 32'(bus.in_ready), 32'd1);
      end
      drive(0, 3'd0, 0, 1, 0);
      cyc();
      cyc();
      chk("pp_empty", 32'(bus.out_valid), 32'd0);
      chk("pp_count", 32'(bus.out_count), 32'd5);

      // accumulator clear, alone and with a transfer
      drive(0, 3'd0, 0, 0, 1);
      cyc();
      chk("clr_acc",   32'(bus.acc_vector), 32'h00);
      chk("clr_count", 32'(bus.out_count),  32'd5);
      drive(1, 3'd3, 0, 0, 0);
      cyc();
      drive(0, 3'd0, 0, 1, 1);
      cyc();
      chk("clr_xfer_acc",   32'(bus.acc_vector), 32'h08);
      chk("clr_xfer_count", 32'(bus.out_count),  32'd6);

      // reset with three entries buffered
      drive(1, 3'd5, 1, 0, 0);
      cyc();
      drive(1, 3'd6, 0, 0, 0);
      cyc();
      drive(1, 3'd2, 1, 0, 0);
      cyc();
      drive(0, 3'd0, 0, 0, 0);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
      drive(0, 3'd0, 0, 1, 0);
      cyc();
      cyc();
      chk("mid_rst_gone",  32'(bus.out_valid), 32'd0);
      chk("mid_rst_count", 32'(bus.out_count), 32'd0);

      // counter wrap
      for (int i = 0; i < 17; i++) begin
         drive(1, 3'(i % 8), 1'(i % 2), 1, 0);
         cyc();
      end
      drive(0, 3'd0, 0, 1, 0);
      cyc();
      chk("wrap_count", 32'(bus.out_count), 32'd1);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         if (bus.in_valid && !m_last_accept) begin
            v = 1'b1;
            code = bus.in_code;
            m = bus.in_mode;
         end else begin
            v = ($urandom_range(0, 3) != 0);
            code = 3'($urandom_range(0, 7));
            m = 1'($urandom_range(0, 1));
         end
         o = ((n / 64) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         c = ($urandom_range(0, 15) == 0);
         drive(v, code, m, o, c);
         reset = ($urandom_range(0, 299) == 0);
         cyc();
      end
      reset = 1'b0;
      drive(0, 3'd0, 0, 1, 0);
      cyc();
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
